// File: rtl/bot_motion_sequencer.sv
// Purpose: queues timed motor commands and plays them to RojoBot MotCtl_in, one per duration.
// Latency: a write into an empty FIFO while idle reaches MotCtl_out one edge after it is sampled.
// Backpressure: writes are dropped when the FIFO is full with no same-edge pop; a drop sets overflow.
module bot_motion_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk50,
    input  logic             Reset_N,
    input  logic             cmd_wr,
    input  logic [15:0]      cmd_data,
    input  logic             upd_tick,
    input  logic             pause,
    input  logic             abort,
    output logic [7:0]       MotCtl_out,
    output logic             busy,
    output logic             cmd_done,
    output logic             cmd_full,
    output logic [CNT_W-1:0] cmd_count,
    output logic             overflow,
    output logic [7:0]       remaining
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t           r_state;
    logic [15:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_tick_prev;
    logic [7:0]       r_mot_out;
    logic [7:0]       r_mot_saved;
    logic [7:0]       r_remaining;
    logic             r_done;
    logic             r_overflow;

    logic             w_tick_edge;
    logic             w_nonempty;
    logic             w_last_tick;
    logic             w_pop;
    logic             w_push;
    logic [15:0]      w_head;
    logic [7:0]       w_head_dur;

    assign w_tick_edge = upd_tick & ~r_tick_prev;
    assign w_nonempty  = (r_count != '0);
    // Final tick of the running command; pause wins over a coincident tick.
    assign w_last_tick = (r_state == RUN) & ~pause & w_tick_edge & (r_remaining == 8'd1);
    assign w_pop       = ~abort & w_nonempty & ((r_state == IDLE) | w_last_tick);
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign w_push      = cmd_wr & ~abort & ((r_count != CNT_W'(DEPTH)) | w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_dur  = (w_head[7:0] == 8'd0) ? 8'd1 : w_head[7:0];

    assign MotCtl_out = r_mot_out;
    assign busy       = (r_state != IDLE);
    assign cmd_done   = r_done;
    assign cmd_full   = (r_count == CNT_W'(DEPTH));
    assign cmd_count  = r_count;
    assign overflow   = r_overflow;
    assign remaining  = r_remaining;

    // Previous upd_tick sample for rising-edge detection, independent of state.
    always_ff @(posedge clk50 or negedge Reset_N) begin
        if (!Reset_N) r_tick_prev <= 1'b0;
        else          r_tick_prev <= upd_tick;
    end

    // Command storage; contents are don't-care whenever the count says empty.
    always_ff @(posedge clk50) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_data;
    end

    // Wrap-around pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk50 or negedge Reset_N) begin
        if (!Reset_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (abort) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (cmd_wr && !w_push) r_overflow <= 1'b1;
        end
    end

    // Sequencer FSM with registered motor byte, countdown and done pulse.
    always_ff @(posedge clk50 or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state     <= IDLE;
            r_mot_out   <= 8'h00;
            r_mot_saved <= 8'h00;
            r_remaining <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= IDLE;
                r_mot_out   <= 8'h00;
                r_mot_saved <= 8'h00;
                r_remaining <= 8'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_pop) begin
                            r_mot_out   <= w_head[15:8];
                            r_mot_saved <= w_head[15:8];
                            r_remaining <= w_head_dur;
                            r_state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            r_mot_out <= 8'h00;
                            r_state   <= PAUSE;
                        end else if (w_tick_edge) begin
                            if (r_remaining == 8'd1) begin
                                r_done <= 1'b1;
                                if (w_pop) begin
                                    r_mot_out   <= w_head[15:8];
                                    r_mot_saved <= w_head[15:8];
                                    r_remaining <= w_head_dur;
                                end else begin
                                    r_mot_out   <= 8'h00;
                                    r_mot_saved <= 8'h00;
                                    r_remaining <= 8'd0;
                                    r_state     <= IDLE;
                                end
                            end else begin
                                r_remaining <= r_remaining - 8'd1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            r_mot_out <= r_mot_saved;
                            r_state   <= RUN;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bot_motion_sequencer.sv
// Purpose: self-checking bench for bot_motion_sequencer with a motor-byte scoreboard.
// Latency: expectations follow the one-edge load and per-tick countdown of the sequencer.
// Backpressure: exercises full FIFO drops, pause hold, abort flush and async reset.
module tb_bot_motion_sequencer;

    logic        clk50;
    logic        Reset_N;
    logic        cmd_wr;
    logic [15:0] cmd_data;
    logic        upd_tick;
    logic        pause;
    logic        abort;
    logic [7:0]  MotCtl_out;
    logic        busy;
    logic        cmd_done;
    logic        cmd_full;
    logic [2:0]  cmd_count;
    logic        overflow;
    logic [7:0]  remaining;

    int          n_chk;
    int          n_fail;
    int          done_cnt;
    logic [7:0]  sb[$];
    logic [7:0]  prev_mot;

    bot_motion_sequencer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk50      (clk50),
        .Reset_N    (Reset_N),
        .cmd_wr     (cmd_wr),
        .cmd_data   (cmd_data),
        .upd_tick   (upd_tick),
        .pause      (pause),
        .abort      (abort),
        .MotCtl_out (MotCtl_out),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .cmd_full   (cmd_full),
        .cmd_count  (cmd_count),
        .overflow   (overflow),
        .remaining  (remaining)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    // Each cmd_done retires the oldest queued motor byte; it must match the byte driven just before.
    always @(negedge clk50) begin
        if (cmd_done === 1'b1) begin
            done_cnt++;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done mot=%h expected no completion", prev_mot);
            end else begin
                logic [7:0] exp_mot;
                exp_mot = sb.pop_front();
                if (prev_mot !== exp_mot) begin
                    n_fail++;
                    $display("FAIL sb_done_mot got=%h exp=%h", prev_mot, exp_mot);
                end
            end
        end
        prev_mot = MotCtl_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [7:0] mot, input logic [7:0] dur, input bit accept);
        cmd_wr   = 1'b1;
        cmd_data = {mot, dur};
        if (accept) sb.push_back(mot);
        @(posedge clk50);
        #1;
        cmd_wr = 1'b0;
    endtask

    task automatic do_tick(output logic d, output logic [7:0] m);
        upd_tick = 1'b1;
        @(posedge clk50);
        @(negedge clk50);
        d = cmd_done;
        m = MotCtl_out;
        upd_tick = 1'b0;
        @(posedge clk50);
        #1;
    endtask

    task automatic test_reset;
        Reset_N = 1'b0; cmd_wr = 1'b0; cmd_data = '0;
        upd_tick = 1'b0; pause = 1'b0; abort = 1'b0;
        #2;
        n_chk++;
        if ({MotCtl_out, remaining, busy, cmd_done, cmd_full, cmd_count, overflow} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs mot=%h rem=%0d busy=%b done=%b full=%b cnt=%0d ovf=%b exp all zero",
                     MotCtl_out, remaining, busy, cmd_done, cmd_full, cmd_count, overflow);
        end
        #10;
        Reset_N = 1'b1;
        @(posedge clk50);
        #1;
    endtask

    task automatic test_single;
        logic d; logic [7:0] m;
        int d0;
        d0 = done_cnt;
        wr(8'h33, 8'd3, 1'b1);
        @(negedge clk50);
        n_chk++;
        if (MotCtl_out !== 8'h00 || cmd_count !== 3'd1) begin
            n_fail++; $display("FAIL single_queued mot=%h cnt=%0d exp 00/1", MotCtl_out, cmd_count);
        end
        @(negedge clk50);
        n_chk++;
        if (MotCtl_out !== 8'h33 || remaining !== 8'd3 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_load mot=%h rem=%0d busy=%b exp 33/3/1", MotCtl_out, remaining, busy);
        end
        do_tick(d, m);
        n_chk++;
        if (remaining !== 8'd2 || d !== 1'b0) begin
            n_fail++; $display("FAIL single_tick1 rem=%0d done=%b exp 2/0", remaining, d);
        end
        do_tick(d, m);
        n_chk++;
        if (remaining !== 8'd1 || d !== 1'b0) begin
            n_fail++; $display("FAIL single_tick2 rem=%0d done=%b exp 1/0", remaining, d);
        end
        do_tick(d, m);
        n_chk++;
        if (d !== 1'b1 || MotCtl_out !== 8'h00 || busy !== 1'b0 || remaining !== 8'd0) begin
            n_fail++; $display("FAIL single_end done=%b mot=%h busy=%b rem=%0d exp 1/00/0/0", d, MotCtl_out, busy, remaining);
        end
        n_chk++;
        if (done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        logic d; logic [7:0] m;
        int d0;
        d0 = done_cnt;
        wr(8'h11, 8'd1, 1'b1);
        wr(8'h22, 8'd2, 1'b1);
        @(negedge clk50);
        n_chk++;
        if (MotCtl_out !== 8'h11 || cmd_count !== 3'd1) begin
            n_fail++; $display("FAIL b2b_first mot=%h cnt=%0d exp 11/1", MotCtl_out, cmd_count);
        end
        do_tick(d, m);
        n_chk++;
        if (d !== 1'b1 || m !== 8'h22 || remaining !== 8'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_switch done=%b mot=%h rem=%0d busy=%b exp 1/22/2/1", d, m, remaining, busy);
        end
        do_tick(d, m);
        do_tick(d, m);
        n_chk++;
        if (d !== 1'b1 || busy !== 1'b0 || MotCtl_out !== 8'h00) begin
            n_fail++; $display("FAIL b2b_end done=%b busy=%b mot=%h exp 1/0/00", d, busy, MotCtl_out);
        end
        n_chk++;
        if (done_cnt - d0 !== 2) begin
            n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0);
        end
    endtask

    task automatic test_overflow;
        logic d; logic [7:0] m;
        int d0;
        d0 = done_cnt;
        wr(8'h55, 8'd5, 1'b1);
        @(posedge clk50);
        #1;
        for (int i = 1; i <= 4; i++) wr(8'h60 + 8'(i), 8'd1, 1'b1);
        n_chk++;
        if (cmd_full !== 1'b1 || cmd_count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full full=%b cnt=%0d ovf=%b exp 1/4/0", cmd_full, cmd_count, overflow);
        end
        wr(8'h65, 8'd1, 1'b0);
        n_chk++;
        if (overflow !== 1'b1 || cmd_count !== 3'd4 || MotCtl_out !== 8'h55) begin
            n_fail++; $display("FAIL ovf_drop ovf=%b cnt=%0d mot=%h exp 1/4/55", overflow, cmd_count, MotCtl_out);
        end
        for (int i = 0; i < 9; i++) do_tick(d, m);
        n_chk++;
        if (done_cnt - d0 !== 5 || busy !== 1'b0 || cmd_count !== 3'd0 || cmd_full !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drain dones=%0d busy=%b cnt=%0d full=%b ovf=%b exp 5/0/0/0/1",
                               done_cnt - d0, busy, cmd_count, cmd_full, overflow);
        end
    endtask

    task automatic test_pause;
        logic d; logic [7:0] m;
        int d0;
        bit bad;
        wr(8'h77, 8'd3, 1'b1);
        @(posedge clk50);
        #1;
        do_tick(d, m);
        d0 = done_cnt;
        pause = 1'b1;
        upd_tick = 1'b1;
        @(posedge clk50);
        @(negedge clk50);
        upd_tick = 1'b0;
        n_chk++;
        if (MotCtl_out !== 8'h00 || remaining !== 8'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pause_enter mot=%h rem=%0d busy=%b exp 00/2/1", MotCtl_out, remaining, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_tick(d, m);
            if (d !== 1'b0 || m !== 8'h00 || remaining !== 8'd2) bad = 1'b1;
        end
        n_chk++;
        if (bad || done_cnt != d0) begin
            n_fail++; $display("FAIL pause_hold mot=%h rem=%0d dones=%0d exp 00/2/0", MotCtl_out, remaining, done_cnt - d0);
        end
        pause = 1'b0;
        @(posedge clk50);
        @(negedge clk50);
        n_chk++;
        if (MotCtl_out !== 8'h77 || remaining !== 8'd2) begin
            n_fail++; $display("FAIL pause_release mot=%h rem=%0d exp 77/2", MotCtl_out, remaining);
        end
        do_tick(d, m);
        do_tick(d, m);
        n_chk++;
        if (d !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL pause_finish done=%b busy=%b exp 1/0", d, busy);
        end
    endtask

    task automatic test_abort;
        int d0;
        wr(8'h88, 8'd5, 1'b1);
        wr(8'h81, 8'd1, 1'b1);
        wr(8'h82, 8'd1, 1'b1);
        wr(8'h83, 8'd1, 1'b1);
        n_chk++;
        if (cmd_count !== 3'd3 || MotCtl_out !== 8'h88 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL abort_setup cnt=%0d mot=%h ovf=%b exp 3/88/1", cmd_count, MotCtl_out, overflow);
        end
        d0 = done_cnt;
        abort = 1'b1;
        cmd_wr = 1'b1;
        cmd_data = 16'h9901;
        sb.delete();
        @(posedge clk50);
        #1;
        abort = 1'b0;
        cmd_wr = 1'b0;
        @(negedge clk50);
        n_chk++;
        if (cmd_count !== 3'd0 || MotCtl_out !== 8'h00 || busy !== 1'b0 || overflow !== 1'b0 || remaining !== 8'd0) begin
            n_fail++; $display("FAIL abort_flush cnt=%0d mot=%h busy=%b ovf=%b rem=%0d exp 0/00/0/0/0",
                               cmd_count, MotCtl_out, busy, overflow, remaining);
        end
        repeat (3) @(negedge clk50);
        n_chk++;
        if (done_cnt != d0 || busy !== 1'b0 || cmd_count !== 3'd0) begin
            n_fail++; $display("FAIL abort_quiet dones=%0d busy=%b cnt=%0d exp 0/0/0", done_cnt - d0, busy, cmd_count);
        end
    endtask

    task automatic test_reset_midrun;
        logic d; logic [7:0] m;
        wr(8'hA5, 8'd4, 1'b1);
        wr(8'hA6, 8'd2, 1'b1);
        do_tick(d, m);
        #3;
        Reset_N = 1'b0;
        upd_tick = 1'b1;
        sb.delete();
        #1;
        n_chk++;
        if ({MotCtl_out, remaining, busy, cmd_done, cmd_full, cmd_count, overflow} !== 23'd0) begin
            n_fail++; $display("FAIL reset_async mot=%h rem=%0d busy=%b done=%b full=%b cnt=%0d ovf=%b exp all zero",
                               MotCtl_out, remaining, busy, cmd_done, cmd_full, cmd_count, overflow);
        end
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        Reset_N = 1'b1;
        @(posedge clk50);
        #1;
        wr(8'h44, 8'd0, 1'b1);
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        n_chk++;
        if (MotCtl_out !== 8'h44 || remaining !== 8'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_dur_load mot=%h rem=%0d busy=%b exp 44/1/1", MotCtl_out, remaining, busy);
        end
        upd_tick = 1'b0;
        @(posedge clk50);
        #1;
        do_tick(d, m);
        n_chk++;
        if (d !== 1'b1 || busy !== 1'b0 || MotCtl_out !== 8'h00) begin
            n_fail++; $display("FAIL zero_dur_end done=%b busy=%b mot=%h exp 1/0/00", d, busy, MotCtl_out);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        prev_mot = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_pause();
        test_abort();
        test_reset_midrun();
        repeat (2) @(posedge clk50);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
